// File: rtl/dist_sched_pkg.sv
// Shared constants and FSM encoding for the distance-unit scheduler.
package dist_sched_pkg;

    localparam int FLOAT_W = 32;
    localparam int VEC_W   = 96;

    localparam logic [FLOAT_W-1:0] FLOAT_QNAN = 32'h7FC0_0000;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t LAUNCH = 2'd1;
    localparam state_t RUN    = 2'd2;
    localparam state_t RESP   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: picks the first request at or
// above ptr, wrapping, and returns it both one-hot and as a binary index.
module rr_arbiter
    import dist_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] j_idx;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j_idx = '0;
        for (int k = 0; k < N; k++) begin
            j_idx = IW'((int'(ptr) + k) % N);
            if (en && !found && req[j_idx]) begin
                found      = 1'b1;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/dist_unit_scheduler.sv
// Round-robin scheduler sharing one restartable float32 distance unit among
// N_REQ requesters. Optional RUN timeout enabled by DIST_SCHED_TIMEOUT_EN.
module dist_unit_scheduler
    import dist_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int RST_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     CLK2,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*96-1:0]      req_a,
    input  logic [N_REQ*96-1:0]      req_b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_err,
    input  logic                     rsp_ack,
    output logic [95:0]              unit_a,
    output logic [95:0]              unit_b,
    output logic                     unit_rst_n,
    input  logic [31:0]              unit_res,
    input  logic                     unit_rdy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(RST_CYC + 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   launch_cnt;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [VEC_W-1:0]   sel_a;
    logic [VEC_W-1:0]   sel_b;
    logic [IDX_W-1:0]   next_ptr;
    logic               timeout;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .en  (state == IDLE),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_a = req_a[i*VEC_W +: VEC_W];
                sel_b = req_b[i*VEC_W +: VEC_W];
            end
        end
    end

    assign next_ptr = (rsp_id == IDX_W'(N_REQ - 1)) ? '0 : rsp_id + IDX_W'(1);

`ifdef DIST_SCHED_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign timeout = (state == RUN) && !unit_rdy && (to_cnt == 16'(TIMEOUT_CYC - 1));

    // A ready in the same cycle as the timeout wins, so rsp_err stays clear.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            to_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state != RUN) to_cnt <= '0;
            else              to_cnt <= to_cnt + 16'd1;
            if (state == RUN) begin
                if (unit_rdy)     rsp_err <= 1'b0;
                else if (timeout) rsp_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            launch_cnt <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            unit_rst_n <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    unit_rst_n <= 1'b0;
                    if (|arb_gnt) begin
                        gnt        <= arb_gnt;
                        rsp_id     <= arb_idx;
                        unit_a     <= sel_a;
                        unit_b     <= sel_b;
                        launch_cnt <= '0;
                        state      <= LAUNCH;
                    end
                end
                // unit_rdy is deliberately not looked at here: it may be stale.
                LAUNCH: begin
                    if (launch_cnt == CNT_W'(RST_CYC - 1)) begin
                        unit_rst_n <= 1'b1;
                        state      <= RUN;
                    end else begin
                        launch_cnt <= launch_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (unit_rdy) begin
                        rsp_data  <= unit_res;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timeout) begin
                        rsp_data  <= FLOAT_QNAN;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp_valid  <= 1'b0;
                        gnt        <= '0;
                        unit_rst_n <= 1'b0;
                        ptr        <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dist_unit_scheduler.sv
// Directed self-checking bench for dist_unit_scheduler with a stub distance unit.
module tb_dist_unit_scheduler;

    localparam int N_REQ       = 4;
    localparam int RST_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int UNIT_LAT    = 3;

    logic                CLK2 = 1'b0;
    logic                RST;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*96-1:0] req_a;
    logic [N_REQ*96-1:0] req_b;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic [31:0]         rsp_data;
    logic [1:0]          rsp_id;
    logic                rsp_err;
    logic                rsp_ack;
    logic [95:0]         unit_a;
    logic [95:0]         unit_b;
    logic                unit_rst_n;
    logic [31:0]         unit_res;
    logic                unit_rdy;

    logic stub_go;
    int   lat_cnt;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK2 = ~CLK2;

    dist_unit_scheduler #(
        .N_REQ      (N_REQ),
        .RST_CYC    (RST_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK2      (CLK2),
        .RST       (RST),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_ack   (rsp_ack),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_rst_n(unit_rst_n),
        .unit_res  (unit_res),
        .unit_rdy  (unit_rdy)
    );

    // Stub unit: sticky ready UNIT_LAT cycles after leaving reset.
    always @(posedge CLK2) begin
        if (!unit_rst_n) begin
            lat_cnt  <= 0;
            unit_rdy <= 1'b0;
        end else if (stub_go) begin
            if (lat_cnt == UNIT_LAT - 1) unit_rdy <= 1'b1;
            else                         lat_cnt  <= lat_cnt + 1;
        end
    end

    assign unit_res = (unit_a == {32'h0, 32'h4080_0000, 32'h4040_0000} && unit_b == 96'h0)
                      ? 32'h40A0_0000 : (unit_a[31:0] ^ unit_b[31:0]);

    function automatic logic [31:0] tag_of(input int i);
        return (32'h3F80_0000 + 32'(i)) ^ 32'(i << 4);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge CLK2);
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus_load_operands();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*96 +: 96] = {32'h0, 32'h0, 32'h3F80_0000 + 32'(i)};
            req_b[i*96 +: 96] = {64'h0, 32'(i << 4)};
        end
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            step(1);
            cyc++;
        end
        checkOutput("rsp_valid_seen", 96'(rsp_valid), 96'(1));
    endtask

    task automatic wait_run();
        int cyc = 0;
        while (unit_rst_n !== 1'b1 && cyc < 50) begin
            step(1);
            cyc++;
        end
        checkOutput("run_reached", 96'(unit_rst_n), 96'(1));
    endtask

    task automatic serve_job(input int exp_id, input logic [31:0] exp_data, input logic [3:0] next_req);
        int cyc;
        wait_rsp(cyc);
        checkOutput("job_id",   96'(rsp_id),   96'(exp_id));
        checkOutput("job_data", 96'(rsp_data), 96'(exp_data));
        checkOutput("job_err",  96'(rsp_err),  96'(0));
        checkOutput("job_gnt",  96'(gnt),      96'(4'b0001 << exp_id));
        rsp_ack = 1'b1;
        req     = next_req;
        step(1);
        rsp_ack = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  low_cyc;
        logic stable;
        logic saw;

        RST     = 1'b0;
        req     = '0;
        rsp_ack = 1'b0;
        stub_go = 1'b1;
        applyStimulus_load_operands();
        step(3);
        checkOutput("rst_gnt",      96'(gnt),        96'(0));
        checkOutput("rst_valid",    96'(rsp_valid),  96'(0));
        checkOutput("rst_data",     96'(rsp_data),   96'(0));
        checkOutput("rst_id",       96'(rsp_id),     96'(0));
        checkOutput("rst_err",      96'(rsp_err),    96'(0));
        checkOutput("rst_unit_rst", 96'(unit_rst_n), 96'(0));
        checkOutput("rst_unit_a",   unit_a,          96'(0));
        RST = 1'b1;
        step(1);

        // Single job: |(3,4,0)| = 5.0
        req_a[96 +: 96] = {32'h0, 32'h4080_0000, 32'h4040_0000};
        req_b[96 +: 96] = 96'h0;
        req = 4'b0010;
        step(1);
        checkOutput("t1_gnt",      96'(gnt),        96'(4'b0010));
        checkOutput("t1_unit_rst", 96'(unit_rst_n), 96'(0));
        checkOutput("t1_unit_a",   unit_a,          {32'h0, 32'h4080_0000, 32'h4040_0000});
        low_cyc = 1;
        while (unit_rst_n == 1'b0 && low_cyc < 10) begin
            step(1);
            if (!unit_rst_n) low_cyc++;
        end
        checkOutput("t1_rst_low_cycles", 96'(low_cyc), 96'(RST_CYC));
        wait_rsp(cyc);
        checkOutput("t1_latency", 96'(cyc),      96'(UNIT_LAT + 1));
        checkOutput("t1_data",    96'(rsp_data), 96'(32'h40A0_0000));
        checkOutput("t1_id",      96'(rsp_id),   96'(1));
        checkOutput("t1_err",     96'(rsp_err),  96'(0));

        // Hold response for 20 cycles without ack
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h40A0_0000 || gnt !== 4'b0010 || rsp_id !== 2'd1)
                stable = 1'b0;
        end
        checkOutput("hold_stable", 96'(stable), 96'(1));
        rsp_ack = 1'b1;
        req     = '0;
        step(1);
        rsp_ack = 1'b0;
        checkOutput("ack_valid",    96'(rsp_valid),  96'(0));
        checkOutput("ack_gnt",      96'(gnt),        96'(0));
        checkOutput("ack_unit_rst", 96'(unit_rst_n), 96'(0));
        checkOutput("ack_unit_a",   unit_a,          {32'h0, 32'h4080_0000, 32'h4040_0000});

        // Async reset in the middle of RUN
        applyStimulus_load_operands();
        req = 4'b1000;
        wait_run();
        checkOutput("ar_gnt_before", 96'(gnt), 96'(4'b1000));
        #2 RST = 1'b0;
        #1;
        checkOutput("ar_gnt",      96'(gnt),        96'(0));
        checkOutput("ar_unit_rst", 96'(unit_rst_n), 96'(0));
        checkOutput("ar_valid",    96'(rsp_valid),  96'(0));
        checkOutput("ar_unit_a",   unit_a,          96'(0));
        req = '0;
        @(negedge CLK2);
        RST = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            saw = saw | rsp_valid;
        end
        checkOutput("ar_no_rsp", 96'(saw), 96'(0));
        req = 4'b1000;
        serve_job(3, tag_of(3), 4'b1111);

        // Fairness with all requesting, then a sparse pattern
        for (int k = 0; k < 8; k++)
            serve_job(k % 4, tag_of(k % 4), (k == 7) ? 4'b1001 : 4'b1111);
        serve_job(0, tag_of(0), 4'b1001);
        serve_job(3, tag_of(3), 4'b1001);
        serve_job(0, tag_of(0), 4'b0101);

        // Requester 2 drops its request and operands change during RUN
        wait_run();
        checkOutput("drop_gnt", 96'(gnt), 96'(4'b0100));
        req = 4'b0001;
        req_a[2*96 +: 96] = {96{1'b1}};
        serve_job(2, tag_of(2), 4'b0001);
        serve_job(0, tag_of(0), 4'b0000);

        // Unit that never becomes ready
        stub_go = 1'b0;
        req     = 4'b0010;
        wait_run();
`ifdef DIST_SCHED_TIMEOUT_EN
        wait_rsp(cyc);
        checkOutput("to_cycle", 96'(cyc),      96'(TIMEOUT_CYC));
        checkOutput("to_err",   96'(rsp_err),  96'(1));
        checkOutput("to_data",  96'(rsp_data), 96'(32'h7FC0_0000));
        checkOutput("to_id",    96'(rsp_id),   96'(1));
        rsp_ack = 1'b1;
        req     = '0;
        step(1);
        rsp_ack = 1'b0;
        checkOutput("to_ack_valid", 96'(rsp_valid), 96'(0));
`else
        saw = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            saw = saw | rsp_valid;
        end
        checkOutput("no_to_rsp", 96'(saw), 96'(0));
        checkOutput("no_to_gnt", 96'(gnt), 96'(4'b0010));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
